shift_arbiter: RTL and testbench

- Shares one 32-bit barrel shifter (`Shifter`) between NREQ requesters, e.g. the EX-stage ALU path and the load/store byte-align path.
- Each requester uses a valid/ready handshake.
- A round-robin arbiter grants one request per cycle. The granted operation goes through the shifter and the result lands in a single-entry registered response stage with backpressure.
- A wrapping completion counter is exported for performance monitoring.

---
 rtl/shift_arbiter_pkg.sv | 25 ++
 rtl/Shifter.sv | 22 ++
 rtl/shift_arbiter.sv | 121 ++++++++++++
 tb/tb_shift_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter: datapath width, shift op
// encodings, response-stage states and the round-robin index helper.
package shift_arbiter_pkg;

    localparam int XLEN   = 32;
    localparam int SHAMTW = 5;

    typedef enum logic [1:0] {
        SHIFT_SRL  = 2'b00,
        SHIFT_SLL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_NONE = 2'b11
    } shift_op_e;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    // Requester index visited k steps after ptr, wrapping modulo n.
    function automatic int rr_next(input int ptr, input int k, input int n);
        return (ptr + k) % n;
    endfunction

endpackage

// File: rtl/Shifter.sv
// Combinational 32-bit barrel shifter: sll, srl, sra or a forced zero result.
module Shifter
    import shift_arbiter_pkg::*;
(
    input  logic [XLEN-1:0]   a_i,
    input  logic [SHAMTW-1:0] shamt_i,
    input  logic [1:0]        type_i,
    output logic [XLEN-1:0]   r_o
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        r_o = '0;
        case (shift_op_e'(type_i))
            SHIFT_SLL: r_o = a_i << shamt_i;
            SHIFT_SRL: r_o = a_i >> shamt_i;
            SHIFT_SRA: r_o = $signed(a_i) >>> shamt_i;
            default:   r_o = '0;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one barrel shifter between NREQ requesters, with a
// single-entry registered response stage and a wrapping completion counter.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*XLEN-1:0]   req_a,
    input  logic [NREQ*SHAMTW-1:0] req_shamt,
    input  logic [NREQ*2-1:0]      req_type,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [XLEN-1:0]        rsp_r,
    input  logic                   rsp_ready,
    output logic [31:0]            done_cnt
);

    rsp_state_e state_q, state_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [XLEN-1:0] rsp_r_q, rsp_r_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [31:0]     done_cnt_q, done_cnt_d;

    logic [XLEN-1:0]   a_arr     [NREQ];
    logic [SHAMTW-1:0] shamt_arr [NREQ];
    logic [1:0]        type_arr  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g]     = req_a[g*XLEN +: XLEN];
        assign shamt_arr[g] = req_shamt[g*SHAMTW +: SHAMTW];
        assign type_arr[g]  = req_type[g*2 +: 2];
    end

    logic           found;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           accept;
    logic           grant;
    logic [XLEN-1:0] shift_r;

    // First valid requester after the last winner, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'(rr_next(int'(rr_ptr_q), k, NREQ));
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // rsp_ready reaches req_ready combinationally so a drain and a load share one cycle.
    assign accept = (state_q == RSP_EMPTY) || rsp_ready;
    assign grant  = rst && accept && found;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[win] = 1'b1;
    end

    Shifter u_shifter (
        .a_i     (a_arr[win]),
        .shamt_i (shamt_arr[win]),
        .type_i  (type_arr[win]),
        .r_o     (shift_r)
    );

    always_comb begin
        state_d    = state_q;
        rsp_id_d   = rsp_id_q;
        rsp_r_d    = rsp_r_q;
        rr_ptr_d   = rr_ptr_q;
        done_cnt_d = done_cnt_q;

        if (state_q == RSP_FULL && rsp_ready) done_cnt_d = done_cnt_q + 32'd1;

        case (state_q)
            RSP_EMPTY: if (grant) state_d = RSP_FULL;
            RSP_FULL:  if (rsp_ready) state_d = grant ? RSP_FULL : RSP_EMPTY;
            default:   state_d = RSP_EMPTY;
        endcase

        if (grant) begin
            rsp_r_d  = shift_r;
            rsp_id_d = win;
            rr_ptr_d = win;
        end
    end

    // NOTE: the reset clears every register; the pointer starts at NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RSP_EMPTY;
            rsp_id_q   <= '0;
            rsp_r_q    <= '0;
            rr_ptr_q   <= IDW'(NREQ - 1);
            done_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            rsp_id_q   <= rsp_id_d;
            rsp_r_q    <= rsp_r_d;
            rr_ptr_q   <= rr_ptr_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign rsp_valid = (state_q == RSP_FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_r     = rsp_r_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter with two requesters.
module tb_shift_arbiter;

    localparam logic [1:0] SRL = 2'b00, SLL = 2'b01, SRA = 2'b10, NONE = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [63:0] req_a;
    logic [9:0]  req_shamt;
    logic [3:0]  req_type;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_r;
    logic        rsp_ready;
    logic [31:0] done_cnt;

    int total = 0;
    int bad   = 0;

    shift_arbiter #(.NREQ(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_shamt (req_shamt),
        .req_type  (req_type),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_r     (rsp_r),
        .rsp_ready (rsp_ready),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    // Requester protocol: a pending request may not drop valid before acceptance.
    logic [1:0] pend_q = 2'b00;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                if (pend_q[i] && !req_valid[i]) begin
                    bad++;
                    $display("FAIL req_drop%0d valid fell to 0 while pending, required 1", i);
                end
            end
        end
        pend_q <= rst ? (req_valid & ~req_ready) : 2'b00;
    end

    task automatic set_req(input int i, input logic v, input logic [31:0] a,
                           input logic [4:0] sh, input logic [1:0] ty);
        req_valid[i]        = v;
        req_a[i*32 +: 32]   = a;
        req_shamt[i*5 +: 5] = sh;
        req_type[i*2 +: 2]  = ty;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        set_req(0, 1'b1, 32'h1, 5'd1, SLL);
        set_req(1, 1'b1, 32'h2, 5'd1, SLL);
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL rst_id got=%h exp=0", rsp_id); end
        total++; if (rsp_r !== 32'h0) begin bad++; $display("FAIL rst_r got=%h exp=0", rsp_r); end
        total++; if (done_cnt !== 32'h0) begin bad++; $display("FAIL rst_cnt got=%h exp=0", done_cnt); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
        step();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_hold_valid got=%b exp=0", rsp_valid); end
        req_valid = 2'b00;
        rst = 1'b1;
    endtask

    task automatic test_single();
        set_req(0, 1'b1, 32'h8000_0001, 5'd4, SRA);
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b exp=01", req_ready); end
        step();
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", rsp_valid); end
        total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL single_id got=%h exp=0", rsp_id); end
        total++; if (rsp_r !== 32'hF800_0000) begin bad++; $display("FAIL single_r got=%h exp=f8000000", rsp_r); end
        total++; if (done_cnt !== 32'd0) begin bad++; $display("FAIL single_cnt0 got=%0d exp=0", done_cnt); end
        req_valid[0] = 1'b0;
        step();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", rsp_valid); end
        total++; if (done_cnt !== 32'd1) begin bad++; $display("FAIL single_cnt1 got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_round_robin();
        logic [0:0]  exp_id;
        logic [31:0] exp_r;
        logic [1:0]  exp_rdy;
        set_req(0, 1'b1, 32'h1, 5'd1, SLL);
        set_req(1, 1'b1, 32'h10, 5'd4, SRL);
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rr_first got=%b exp=01", req_ready); end
        for (int n = 0; n < 4; n++) begin
            exp_id  = 1'(n % 2);
            exp_r   = (n % 2 == 0) ? 32'h2 : 32'h1;
            exp_rdy = (n % 2 == 0) ? 2'b10 : 2'b01;
            step();
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rr_valid%0d got=%b exp=1", n, rsp_valid); end
            total++; if (rsp_id !== exp_id) begin bad++; $display("FAIL rr_id%0d got=%h exp=%h", n, rsp_id, exp_id); end
            total++; if (rsp_r !== exp_r) begin bad++; $display("FAIL rr_r%0d got=%h exp=%h", n, rsp_r, exp_r); end
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_ready%0d got=%b exp=%b", n, req_ready, exp_rdy); end
        end
        req_valid[1] = 1'b0;
        step();
        total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL rr_tail_id got=%h exp=0", rsp_id); end
        req_valid[0] = 1'b0;
        step();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rr_drain got=%b exp=0", rsp_valid); end
        total++; if (done_cnt !== 32'd5) begin bad++; $display("FAIL rr_cnt got=%0d exp=5", done_cnt); end
    endtask

    task automatic test_backpressure();
        set_req(0, 1'b1, 32'h5, 5'd2, SLL);
        rsp_ready = 1'b1;
        step();
        total++; if (rsp_r !== 32'h14) begin bad++; $display("FAIL bp_first got=%h exp=14", rsp_r); end
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 32'h7, 5'd1, SRL);
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL bp_ready got=%b exp=00", req_ready); end
        for (int n = 0; n < 3; n++) begin
            step();
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d got=%b exp=1", n, rsp_valid); end
            total++; if (rsp_r !== 32'h14) begin bad++; $display("FAIL bp_hold_r%0d got=%h exp=14", n, rsp_r); end
            total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL bp_hold_id%0d got=%h exp=0", n, rsp_id); end
            total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL bp_stall%0d got=%b exp=00", n, req_ready); end
        end
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL bp_release got=%b exp=01", req_ready); end
        step();
        total++; if (rsp_r !== 32'h3) begin bad++; $display("FAIL bp_next_r got=%h exp=3", rsp_r); end
        total++; if (done_cnt !== 32'd6) begin bad++; $display("FAIL bp_cnt6 got=%0d exp=6", done_cnt); end
        req_valid[0] = 1'b0;
        step();
        total++; if (done_cnt !== 32'd7) begin bad++; $display("FAIL bp_cnt7 got=%0d exp=7", done_cnt); end
    endtask

    task automatic test_edge_ops();
        int          t_req [5] = '{0, 1, 0, 1, 0};
        logic [31:0] t_a   [5] = '{32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h3, 32'h8000_0000, 32'h7000_0000};
        logic [4:0]  t_sh  [5] = '{5'd0, 5'd3, 5'd31, 5'd31, 5'd4};
        logic [1:0]  t_ty  [5] = '{SRL, NONE, SLL, SRA, SRA};
        logic [31:0] t_exp [5] = '{32'hDEAD_BEEF, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0700_0000};
        rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            req_valid = 2'b00;
            set_req(t_req[n], 1'b1, t_a[n], t_sh[n], t_ty[n]);
            step();
            total++; if (rsp_r !== t_exp[n]) begin bad++; $display("FAIL edge_r%0d got=%h exp=%h", n, rsp_r, t_exp[n]); end
            total++; if (rsp_id !== 1'(t_req[n])) begin bad++; $display("FAIL edge_id%0d got=%h exp=%0d", n, rsp_id, t_req[n]); end
        end
        req_valid = 2'b00;
        step();
        total++; if (done_cnt !== 32'd12) begin bad++; $display("FAIL edge_cnt got=%0d exp=12", done_cnt); end
    endtask

    task automatic test_reset_mid();
        set_req(0, 1'b1, 32'h1234_5678, 5'd8, SRL);
        rsp_ready = 1'b0;
        step();
        total++; if (rsp_r !== 32'h0012_3456) begin bad++; $display("FAIL mid_r got=%h exp=00123456", rsp_r); end
        req_valid[0] = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", rsp_valid); end
        total++; if (done_cnt !== 32'd0) begin bad++; $display("FAIL mid_cnt got=%0d exp=0", done_cnt); end
        total++; if (rsp_r !== 32'h0) begin bad++; $display("FAIL mid_clr_r got=%h exp=0", rsp_r); end
        set_req(0, 1'b1, 32'h1, 5'd1, SLL);
        set_req(1, 1'b1, 32'h2, 5'd1, SLL);
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL mid_rst_ready got=%b exp=00", req_ready); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL mid_first got=%b exp=01", req_ready); end
        step();
        total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL mid_id0 got=%h exp=0", rsp_id); end
        total++; if (rsp_r !== 32'h2) begin bad++; $display("FAIL mid_r0 got=%h exp=2", rsp_r); end
        req_valid[0] = 1'b0;
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL mid_second got=%b exp=10", req_ready); end
        step();
        total++; if (rsp_id !== 1'b1) begin bad++; $display("FAIL mid_id1 got=%h exp=1", rsp_id); end
        total++; if (rsp_r !== 32'h4) begin bad++; $display("FAIL mid_r1 got=%h exp=4", rsp_r); end
        total++; if (done_cnt !== 32'd1) begin bad++; $display("FAIL mid_cnt1 got=%0d exp=1", done_cnt); end
        req_valid[1] = 1'b0;
        step();
        total++; if (done_cnt !== 32'd2) begin bad++; $display("FAIL mid_cnt2 got=%0d exp=2", done_cnt); end
    endtask

    task automatic test_wrap();
        force dut.done_cnt_q = 32'hFFFF_FFFF;
        #1;
        total++; if (done_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_forced got=%h exp=ffffffff", done_cnt); end
        step();
        release dut.done_cnt_q;
        #1;
        total++; if (done_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_held got=%h exp=ffffffff", done_cnt); end
        set_req(0, 1'b1, 32'h1, 5'd0, SLL);
        rsp_ready = 1'b1;
        step();
        req_valid[0] = 1'b0;
        total++; if (done_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_pre got=%h exp=ffffffff", done_cnt); end
        step();
        total++; if (done_cnt !== 32'h0) begin bad++; $display("FAIL wrap_zero got=%h exp=0", done_cnt); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wrap_drain got=%b exp=0", rsp_valid); end
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_shamt = '0;
        req_type  = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        do_reset();
        test_round_robin();
        test_backpressure();
        test_edge_ops();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
